// File: rtl/demorgan_sweep_checker.sv
// ---------------------------------------------------------------------------
// demorgan_sweep_checker
//
// Purpose:
//   Exercises an external two-input AND/NAND gate pair over its full truth
//   table. The vectors are (A,B) = 00, 01, 10, 11, in that order. Each vector
//   is driven for SETTLE cycles. The gate outputs are then sampled and
//   checked against A&B and ~(A&B). Failing vectors are recorded in
//   fail_mask and counted in err_count. pass is raised only when a sweep
//   finishes with no failing vector.
//
// Parameters:
//   SETTLE     cycles each vector is held before it is sampled (1..15)
//
// Ports:
//   clk        single clock, rising-edge active
//   reset      synchronous, active-high reset; takes priority over start
//   start      request one sweep; accepted only while idle
//   and_in     AND output of the gate under test
//   nand_in    NAND output of the gate under test
//   a_out      A stimulus to the gate under test (0 when not sweeping)
//   b_out      B stimulus to the gate under test (0 when not sweeping)
//   busy       high while a sweep is in progress
//   done       one-cycle pulse after the last vector has been sampled
//   pass       high after a sweep that found no failing vector
//   err_count  number of failing vectors in the last sweep (0..4)
//   fail_mask  bit i set when vector i failed in the last sweep
//
//   All outputs are registered. The results (pass, err_count and
//   fail_mask) hold their values until the next accepted start or reset.
// ---------------------------------------------------------------------------
module demorgan_sweep_checker #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       and_in,
   input  logic       nand_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [1:0]  idx_r;
   logic [1:0]  idx_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_s;
   logic        a_s;
   logic        b_s;
   logic        busy_s;
   logic        done_s;
   logic        pass_s;
   logic [2:0]  err_s;
   logic [3:0]  mask_s;
   logic        fail_s;

   // A vector fails when either gate output disagrees with the ideal product.
   function automatic logic vector_fail(input logic a, input logic b,
                                        input logic and_v, input logic nand_v);
      logic prod;
      prod = a & b;
      return (and_v != prod) || (nand_v != ~prod);
   endfunction

   // Next-state and next-output logic for the sweep sequencer.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      a_s     = 1'b0;
      b_s     = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      pass_s  = pass;
      err_s   = err_count;
      mask_s  = fail_mask;
      fail_s  = 1'b0;

      case (state_r)
         IDLE: begin
            if (start) begin
               // Clear the previous results and drive vector 0 (A=0, B=0).
               state_s = WAIT;
               idx_s   = 2'd0;
               cnt_s   = SETTLE_C;
               a_s     = 1'b0;
               b_s     = 1'b0;
               busy_s  = 1'b1;
               pass_s  = 1'b0;
               err_s   = 3'd0;
               mask_s  = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end

         WAIT: begin
            busy_s = 1'b1;
            a_s    = a_out;
            b_s    = b_out;
            if (cnt_r == 4'd1) begin
               // Last cycle of the settle window: the sample is taken now.
               fail_s         = vector_fail(a_out, b_out, and_in, nand_in);
               err_s          = err_count + {2'b00, fail_s};
               mask_s[idx_r]  = fail_mask[idx_r] | fail_s;
               if (idx_r == 2'd3) begin
                  // pass is based on the count that includes this last vector.
                  state_s = DONE;
                  a_s     = 1'b0;
                  b_s     = 1'b0;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  pass_s  = (err_s == 3'd0);
               end else begin
                  idx_s = idx_r + 2'd1;
                  a_s   = idx_s[1];
                  b_s   = idx_s[0];
                  cnt_s = SETTLE_C;
               end
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end

         DONE: begin
            // done lasts one cycle; a start seen here is deliberately dropped.
            state_s = IDLE;
         end

         default: begin
            state_s = IDLE;
            idx_s   = 2'd0;
            cnt_s   = 4'd0;
            pass_s  = 1'b0;
            err_s   = 3'd0;
            mask_s  = 4'd0;
         end
      endcase
   end

   // State, sequencing and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         idx_r     <= 2'd0;
         cnt_r     <= 4'd0;
         a_out     <= 1'b0;
         b_out     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
         fail_mask <= 4'd0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         cnt_r     <= cnt_s;
         a_out     <= a_s;
         b_out     <= b_s;
         busy      <= busy_s;
         done      <= done_s;
         pass      <= pass_s;
         err_count <= err_s;
         fail_mask <= mask_s;
      end
   end

endmodule
